// File: rtl/rgb_pwm_fader.sv
// Smooths on/off colour flags into linearly ramped PWM levels driving active-low RGB pins.
// Optional GAMMA_EN: squares the level before the duty compare, adding one register stage.
module rgb_pwm_fader #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 23529,
  parameter int STEP_SIZE   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic red,
  input  logic green,
  input  logic blue,
  output logic led_r_n,
  output logic led_g_n,
  output logic led_b_n,
  output logic settled
);

  localparam int PRE_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   STEP     = (PWM_BITS+1)'(STEP_SIZE);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} ch_state_t;

  // Sums/differences are formed one bit wider so an oversized step clamps instead of wrapping.
  function automatic logic [PWM_BITS-1:0] sat_up(input logic [PWM_BITS-1:0] lv);
    logic [PWM_BITS:0] sum;
    sum = {1'b0, lv} + STEP;
    return (sum >= {1'b0, MAX}) ? MAX : sum[PWM_BITS-1:0];
  endfunction

  function automatic logic [PWM_BITS-1:0] sat_down(input logic [PWM_BITS-1:0] lv);
    logic [PWM_BITS:0] diff;
    diff = {1'b0, lv} - STEP;
    return ({1'b0, lv} <= STEP) ? '0 : diff[PWM_BITS-1:0];
  endfunction

`ifdef GAMMA_EN
  function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] lv);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, lv} * {{PWM_BITS{1'b0}}, lv};
    return (lv == MAX) ? MAX : sq[2*PWM_BITS-1:PWM_BITS];
  endfunction
`endif

  logic [2:0]          flag_p0;
  logic [PRE_W-1:0]    prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level [3];
  ch_state_t           state [3];
  logic [PWM_BITS-1:0] lv_up [3];
  logic [PWM_BITS-1:0] lv_dn [3];
  logic [PWM_BITS-1:0] duty  [3];
  logic [2:0]          on;
  logic                all_settled;
  logic                step_tick;

  assign step_tick = (prescaler == PRE_LAST);

  always_comb begin
    all_settled = 1'b1;
    for (int c = 0; c < 3; c++) begin
      lv_up[c] = sat_up(level[c]);
      lv_dn[c] = sat_down(level[c]);
      if (!((state[c] == OFF || state[c] == ON) &&
            (level[c] == (flag_p0[c] ? MAX : '0))))
        all_settled = 1'b0;
    end
  end

  // Stage p0: input sampling, timebase, per-channel ramp state machines
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_p0   <= '0;
      prescaler <= '0;
      pwm_cnt   <= '0;
      for (int c = 0; c < 3; c++) begin
        level[c] <= '0;
        state[c] <= OFF;
      end
    end else begin
      flag_p0   <= {blue, green, red};
      prescaler <= step_tick ? '0 : prescaler + PRE_W'(1);
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      if (step_tick) begin
        for (int c = 0; c < 3; c++) begin
          case (state[c])
            OFF: begin
              if (flag_p0[c]) begin
                level[c] <= lv_up[c];
                state[c] <= (lv_up[c] == MAX) ? ON : RAMP_UP;
              end
            end
            ON: begin
              if (!flag_p0[c]) begin
                level[c] <= lv_dn[c];
                state[c] <= (lv_dn[c] == '0) ? OFF : RAMP_DOWN;
              end
            end
            RAMP_UP, RAMP_DOWN: begin
              if (flag_p0[c]) begin
                level[c] <= lv_up[c];
                state[c] <= (lv_up[c] == MAX) ? ON : RAMP_UP;
              end else begin
                level[c] <= lv_dn[c];
                state[c] <= (lv_dn[c] == '0) ? OFF : RAMP_DOWN;
              end
            end
            default: state[c] <= OFF;
          endcase
        end
      end
    end
  end

`ifdef GAMMA_EN
  logic [PWM_BITS-1:0] gl_p1 [3];

  // Stage p1: gamma-corrected duty level
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) gl_p1[c] <= '0;
    end else begin
      for (int c = 0; c < 3; c++) gl_p1[c] <= gamma(level[c]);
    end
  end

  always_comb begin
    for (int c = 0; c < 3; c++) duty[c] = gl_p1[c];
  end
`else
  always_comb begin
    for (int c = 0; c < 3; c++) duty[c] = level[c];
  end
`endif

  // Full level bypasses the compare so MAX means 100% on rather than MAX/(MAX+1).
  always_comb begin
    for (int c = 0; c < 3; c++)
      on[c] = (duty[c] == MAX) || (pwm_cnt < duty[c]);
  end

  // Output stage: registered pin drive and settled flag
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r_n <= 1'b1;
      led_g_n <= 1'b1;
      led_b_n <= 1'b1;
      settled <= 1'b0;
    end else begin
      led_r_n <= ~on[0];
      led_g_n <= ~on[1];
      led_b_n <= ~on[2];
      settled <= all_settled;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: two instances (step 1 and step 4) checked every cycle
// against a time-since-reset reference model, directed phases then random stimulus.
module tb_rgb_pwm_fader;

  localparam int PB   = 4;
  localparam int SC   = 4;
  localparam int MAXV = 15;
  localparam int PER  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic red = 1'b0, green = 1'b0, blue = 1'b0;
  logic [1:0][2:0] led_n;
  logic [1:0]      settled;

  rgb_pwm_fader #(.PWM_BITS(PB), .STEP_CYCLES(SC), .STEP_SIZE(1)) dut_s1 (
    .clk(clk), .rst(rst), .red(red), .green(green), .blue(blue),
    .led_r_n(led_n[0][0]), .led_g_n(led_n[0][1]), .led_b_n(led_n[0][2]),
    .settled(settled[0])
  );

  rgb_pwm_fader #(.PWM_BITS(PB), .STEP_CYCLES(SC), .STEP_SIZE(4)) dut_s4 (
    .clk(clk), .rst(rst), .red(red), .green(green), .blue(blue),
    .led_r_n(led_n[1][0]), .led_g_n(led_n[1][1]), .led_b_n(led_n[1][2]),
    .settled(settled[1])
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: everything derives from the count of cycles since reset release.
  int m_cnt = 0;
  int m_lvl [2][3] = '{default: 0};
  bit m_flag [3]   = '{default: 1'b0};
  bit m_led [2][3] = '{default: 1'b1};
  bit m_set [2]    = '{default: 1'b0};

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
      for (int d = 0; d < 2; d++) begin
        m_set[d] = 1'b0;
        for (int c = 0; c < 3; c++) begin
          m_lvl[d][c] = 0;
          m_led[d][c] = 1'b1;
        end
      end
      for (int c = 0; c < 3; c++) m_flag[c] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_set[d] = 1'b1;
        for (int c = 0; c < 3; c++) begin
          m_led[d][c] = !(m_lvl[d][c] == MAXV || (m_cnt % PER) < m_lvl[d][c]);
          if (m_lvl[d][c] != (m_flag[c] ? MAXV : 0)) m_set[d] = 1'b0;
        end
      end
      if (m_cnt % SC == SC - 1) begin
        for (int d = 0; d < 2; d++) begin
          for (int c = 0; c < 3; c++) begin
            int tgt, stp;
            tgt = m_flag[c] ? MAXV : 0;
            stp = (d == 0) ? 1 : 4;
            if (m_lvl[d][c] < tgt)
              m_lvl[d][c] = (m_lvl[d][c] + stp > tgt) ? tgt : m_lvl[d][c] + stp;
            else if (m_lvl[d][c] > tgt)
              m_lvl[d][c] = (m_lvl[d][c] - stp < 0) ? 0 : m_lvl[d][c] - stp;
          end
        end
      end
      m_flag[0] = red;
      m_flag[1] = green;
      m_flag[2] = blue;
      m_cnt++;
    end
  end

  task automatic check_pins(input string tag);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 3; c++) begin
        total++;
        assert (led_n[d][c] === m_led[d][c]) else begin
          bad++;
          $error("FAIL %s dut%0d ch%0d led_n observed=%b expected=%b",
                 tag, d, c, led_n[d][c], m_led[d][c]);
        end
      end
      total++;
      assert (settled[d] === m_set[d]) else begin
        bad++;
        $error("FAIL %s dut%0d settled observed=%b expected=%b",
               tag, d, settled[d], m_set[d]);
      end
    end
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      check_pins(tag);
    end
  endtask

  task automatic wait_level(input int d, input int c, input int lv, input string tag);
    int k;
    k = 0;
    while (m_lvl[d][c] != lv && k < 200) begin
      run(1, tag);
      k++;
    end
    total++;
    assert (k < 200) else begin
      bad++;
      $error("FAIL %s timeout waiting level observed=%0d expected=%0d", tag, m_lvl[d][c], lv);
    end
  endtask

  initial begin
    // Reset held with all flags high
    red = 1'b1; green = 1'b1; blue = 1'b1;
    run(3, "reset");
    total++;
    assert (led_n === 6'b111111 && settled === 2'b00) else begin
      bad++;
      $error("FAIL reset_const observed=%b/%b expected=111111/00", led_n, settled);
    end

    // Ramp up red; step-4 instance exercises clamping at MAX
    rst = 1'b0; green = 1'b0; blue = 1'b0;
    run(80, "ramp_up");
    total++;
    assert (settled === 2'b11 && led_n[0] === 3'b110) else begin
      bad++;
      $error("FAIL ramp_done observed=%b/%b expected=11/110", settled, led_n[0]);
    end

    // Ramp down to OFF, no underflow
    red = 1'b0;
    run(80, "ramp_down");

    // Reversal at level 6
    red = 1'b1;
    wait_level(0, 0, 6, "rev_up");
    red = 1'b0;
    run(40, "rev_down");

    // Crossfade green -> red
    green = 1'b1;
    run(80, "green_up");
    red = 1'b1; green = 1'b0;
    run(80, "crossfade");
    red = 1'b0;

    // Reset mid-ramp at blue level 9
    blue = 1'b1;
    wait_level(0, 2, 9, "blue_up");
    rst = 1'b1;
    run(1, "mid_reset");
    total++;
    assert (led_n[0][2] === 1'b1 && settled[0] === 1'b0) else begin
      bad++;
      $error("FAIL mid_reset_const observed=%b/%b expected=1/0", led_n[0][2], settled[0]);
    end
    rst = 1'b0;
    run(40, "restart");

    // Random flags with occasional resets
    for (int i = 0; i < 250; i++) begin
      red   = 1'($urandom_range(0, 1));
      green = 1'($urandom_range(0, 1));
      blue  = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 29) == 0);
      run(1, "rand_rst");
      rst = 1'b0;
      run($urandom_range(1, 40), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
